// File: rtl/ysyx_22041211_ifu_prefetch_pkg.sv
// ysyx_22041211_ifu_prefetch_pkg: IFU state encoding, reset PC default and RV32 opcode constants.
package ysyx_22041211_ifu_prefetch_pkg;
   typedef enum logic [1:0] {IDLE, ADDR, DATA, HALT} ifu_state_t;
   localparam logic [31:0] RESET_PC_DEF = 32'h8000_0000;
   localparam logic [6:0] OP_LUI = 7'b0110111, OP_AUIPC = 7'b0010111, OP_JAL = 7'b1101111,
                          OP_JALR = 7'b1100111, OP_BRANCH = 7'b1100011, OP_LOAD = 7'b0000011,
                          OP_STORE = 7'b0100011, OP_IMM = 7'b0010011, OP_REG = 7'b0110011,
                          OP_SYSTEM = 7'b1110011;
   localparam logic [2:0] F3_SLL = 3'b001, F3_SR = 3'b101, F3_CSRRW = 3'b001, F3_CSRRS = 3'b010;
   localparam logic [6:0] F7_ALT = 7'b0100000;
   // Only elaborated into hardware where a caller exists.
   function automatic logic inst_legal(input logic [31:0] i);
      logic [6:0] op;
      logic [2:0] f3;
      logic [6:0] f7;
      op = i[6:0];
      f3 = i[14:12];
      f7 = i[31:25];
      return op == OP_LUI || op == OP_AUIPC || op == OP_JAL
         || (op == OP_JALR && f3 == 3'b000)
         || (op == OP_BRANCH && f3[2:1] != 2'b01)
         || (op == OP_LOAD && (f3 == 3'b000 || f3 == 3'b001 || f3 == 3'b010 || f3 == 3'b100 || f3 == 3'b101))
         || (op == OP_STORE && (f3 == 3'b000 || f3 == 3'b001 || f3 == 3'b010))
         || (op == OP_IMM && (f3 == F3_SLL ? f7 == 7'b0 : f3 == F3_SR ? (f7 == 7'b0 || f7 == F7_ALT) : 1'b1))
         || (op == OP_REG && (f7 == 7'b0 || (f7 == F7_ALT && (f3 == 3'b000 || f3 == F3_SR))))
         || (op == OP_SYSTEM && (f3 == F3_CSRRW || f3 == F3_CSRRS
            || i == 32'h0000_0073 || i == 32'h0010_0073 || i == 32'h3020_0073));
   endfunction
endpackage

// File: rtl/ysyx_22041211_ifu_prefetch_if.sv
// ysyx_22041211_ifu_prefetch_if: redirect, IDU stream and AXI4-Lite AR/R signals of the IFU.
interface ysyx_22041211_ifu_prefetch_if #(parameter int ADDR_WIDTH = 32, parameter int DATA_WIDTH = 32);
   logic                  redirect_valid_i;
   logic [ADDR_WIDTH-1:0] redirect_pc_i;
   logic                  out_valid_o;
   logic                  out_ready_i;
   logic [DATA_WIDTH-1:0] out_inst_o;
   logic [ADDR_WIDTH-1:0] out_pc_o;
   logic                  out_fault_o;
   logic                  out_illegal_o;
   logic [ADDR_WIDTH-1:0] araddr_o;
   logic                  arvalid_o;
   logic                  arready_i;
   logic [DATA_WIDTH-1:0] rdata_i;
   logic [1:0]            rresp_i;
   logic                  rvalid_i;
   logic                  rready_o;
   modport master (
      input  redirect_valid_i, redirect_pc_i, out_ready_i, arready_i, rdata_i, rresp_i, rvalid_i,
      output out_valid_o, out_inst_o, out_pc_o, out_fault_o, out_illegal_o, araddr_o, arvalid_o, rready_o
   );
   modport slave (
      output redirect_valid_i, redirect_pc_i, out_ready_i, arready_i, rdata_i, rresp_i, rvalid_i,
      input  out_valid_o, out_inst_o, out_pc_o, out_fault_o, out_illegal_o, araddr_o, arvalid_o, rready_o
   );
endinterface

// File: rtl/ysyx_22041211_ifu_prefetch_fifo.sv
// ysyx_22041211_ifu_fifo: synchronous prefetch FIFO with flush; head read straight from storage.
module ysyx_22041211_ifu_fifo #(
   parameter int DEPTH = 4,
   parameter int WIDTH = 65
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     push,
   input  logic                     pop,
   input  logic                     flush,
   input  logic [WIDTH-1:0]         wdata,
   output logic [WIDTH-1:0]         rdata,
   output logic                     full,
   output logic                     empty,
   output logic [$clog2(DEPTH):0]   count
);
   localparam int AW = $clog2(DEPTH);
   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    rd_ptr, wr_ptr;
   logic             rd, wr;
   assign rd    = pop && !empty;
   assign wr    = push && (!full || rd);
   assign full  = count == (AW+1)'(DEPTH);
   assign empty = count == '0;
   assign rdata = mem[rd_ptr];
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         rd_ptr <= '0;
         wr_ptr <= '0;
         count  <= '0;
      end else if (flush) begin
         rd_ptr <= '0;
         wr_ptr <= '0;
         count  <= '0;
      end else begin
         rd_ptr <= rd_ptr + AW'(rd);
         wr_ptr <= wr_ptr + AW'(wr);
         count  <= count + (AW+1)'(wr) - (AW+1)'(rd);
      end
   always_ff @(posedge clk)
      if (wr) mem[wr_ptr] <= wdata;
endmodule

// File: rtl/ysyx_22041211_ifu_prefetch.sv
// ysyx_22041211_ifu_prefetch: sequential prefetching IFU, one AXI4-Lite read in flight, flush on redirect.
// IFU_INST_CHECK_EN builds the out_illegal_o opcode decoder; otherwise it is tied low.
module ysyx_22041211_ifu_prefetch
   import ysyx_22041211_ifu_prefetch_pkg::*;
#(
   parameter int              ADDR_WIDTH = 32,
   parameter int              DATA_WIDTH = 32,
   parameter int              FIFO_DEPTH = 4,
   parameter logic [ADDR_WIDTH-1:0] RESET_PC = ADDR_WIDTH'(RESET_PC_DEF)
) (
   input logic clk,
   input logic rst_n,
   ysyx_22041211_ifu_prefetch_if.master bus
);
   localparam int EW = ADDR_WIDTH + DATA_WIDTH + 1;
   localparam int CW = $clog2(FIFO_DEPTH) + 1;
   ifu_state_t            state;
   logic                  drop, push, pop, full, empty, rx;
   logic [ADDR_WIDTH-1:0] fetch_pc;
   logic [EW-1:0]         head, push_data;
   logic [CW-1:0]         count;
   assign rx        = state == DATA && bus.rvalid_i;
   assign push      = rx && !drop && !bus.redirect_valid_i && (!full || pop);
   assign pop       = bus.out_valid_o && bus.out_ready_i;
   assign push_data = bus.rresp_i == 2'b00 ? {fetch_pc, bus.rdata_i, 1'b0} : {fetch_pc, {DATA_WIDTH{1'b0}}, 1'b1};
   ysyx_22041211_ifu_fifo #(.DEPTH(FIFO_DEPTH), .WIDTH(EW)) u_fifo (
      .clk(clk), .rst_n(rst_n), .push(push), .pop(pop), .flush(bus.redirect_valid_i),
      .wdata(push_data), .rdata(head), .full(full), .empty(empty), .count(count)
   );
   assign bus.out_valid_o = !empty;
   assign {bus.out_pc_o, bus.out_inst_o, bus.out_fault_o} = head;
`ifdef IFU_INST_CHECK_EN
   assign bus.out_illegal_o = !bus.out_fault_o && !inst_legal(bus.out_inst_o);
`else
   assign bus.out_illegal_o = 1'b0;
`endif
   // A redirect never withdraws an accepted or presented AR; the reply is marked for discard instead.
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         state         <= IDLE;
         bus.arvalid_o <= 1'b0;
         bus.araddr_o  <= '0;
         bus.rready_o  <= 1'b0;
         fetch_pc      <= RESET_PC;
         drop          <= 1'b0;
      end else begin
         if (bus.redirect_valid_i) fetch_pc <= bus.redirect_pc_i;
         else if (push && bus.rresp_i == 2'b00) fetch_pc <= fetch_pc + ADDR_WIDTH'(4);
         case (state)
            IDLE: if (!bus.redirect_valid_i && count < CW'(FIFO_DEPTH)) begin
               state         <= ADDR;
               bus.arvalid_o <= 1'b1;
               bus.araddr_o  <= fetch_pc;
            end
            ADDR: begin
               if (bus.redirect_valid_i) drop <= 1'b1;
               if (bus.arready_i) begin
                  state         <= DATA;
                  bus.arvalid_o <= 1'b0;
                  bus.rready_o  <= 1'b1;
               end
            end
            DATA: if (bus.rvalid_i) begin
               state        <= push && bus.rresp_i != 2'b00 ? HALT : IDLE;
               bus.rready_o <= 1'b0;
               drop         <= 1'b0;
            end else if (bus.redirect_valid_i) drop <= 1'b1;
            HALT: if (bus.redirect_valid_i) state <= IDLE;
            default: state <= IDLE;
         endcase
      end
endmodule

// File: tb/tb_ysyx_22041211_ifu_prefetch.sv
// tb_ysyx_22041211_ifu_prefetch: directed and random stimulus against a stream/scoreboard model of the IFU.
module tb_ysyx_22041211_ifu_prefetch;
   localparam int DEPTH = 4;
   typedef struct packed {logic [31:0] pc; logic [31:0] inst; logic fault;} ent_t;
   logic clk = 1'b0, rst_n = 1'b0;
   always #5 clk = ~clk;
   ysyx_22041211_ifu_prefetch_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) bus ();
   ysyx_22041211_ifu_prefetch #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .FIFO_DEPTH(DEPTH), .RESET_PC(32'h8000_0000)) dut (
      .clk(clk), .rst_n(rst_n), .bus(bus)
   );
   int vectors = 0, miscompares = 0;
   ent_t q[$];
   logic [31:0] ar_log[$];
   logic [31:0] fetch_pc, pend_addr, prev_aa, fault_addr, redir_target, const_data;
   bit pend, stale, halted, prev_av, fault_en, const_en, force_redir, saw_fault, s_av, s_ov;
   logic s_oi;
   int rwait, rdelay, p_ar, p_rdy, p_redir, p_fault, ar_count;
`ifdef IFU_INST_CHECK_EN
   localparam logic [31:0] M7 = 32'h7F, M3 = 32'h707F, MR = 32'hFE00707F, MA = 32'hFFFFFFFF;
   localparam logic [63:0] PAT [42] = '{
      {M7,32'h37},{M7,32'h17},{M7,32'h6F},{M3,32'h67},
      {M3,32'h63},{M3,32'h1063},{M3,32'h4063},{M3,32'h5063},{M3,32'h6063},{M3,32'h7063},
      {M3,32'h03},{M3,32'h1003},{M3,32'h2003},{M3,32'h4003},{M3,32'h5003},
      {M3,32'h23},{M3,32'h1023},{M3,32'h2023},
      {M3,32'h13},{M3,32'h2013},{M3,32'h3013},{M3,32'h4013},{M3,32'h6013},{M3,32'h7013},
      {MR,32'h1013},{MR,32'h5013},{MR,32'h40005013},
      {MR,32'h33},{MR,32'h40000033},{MR,32'h1033},{MR,32'h2033},{MR,32'h3033},
      {MR,32'h4033},{MR,32'h5033},{MR,32'h40005033},{MR,32'h6033},{MR,32'h7033},
      {M3,32'h1073},{M3,32'h2073},{MA,32'h73},{MA,32'h00100073},{MA,32'h30200073}};
   localparam logic ILL_FF = 1'b1;
   function automatic bit legal(logic [31:0] i);
      logic [63:0] p;
      foreach (PAT[k]) begin
         p = PAT[k];
         if ((i & p[63:32]) == p[31:0]) return 1'b1;
      end
      return 1'b0;
   endfunction
`else
   localparam logic ILL_FF = 1'b0;
`endif
   function automatic logic [31:0] mem_word(logic [31:0] a);
      return const_en ? const_data : (a * 32'h9E37_79B1) ^ 32'h0000_0013;
   endfunction
   task automatic chk(string tag, logic [63:0] obs, logic [63:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask
   task automatic step();
      logic av, rr, ov, rd, ar_hs, r_hs, o_hs, rf;
      logic [31:0] aa, tgt, rdat;
      @(negedge clk);
      av = bus.arvalid_o; aa = bus.araddr_o; rr = bus.rready_o; ov = bus.out_valid_o;
      s_av = av; s_ov = ov; s_oi = bus.out_illegal_o;
      saw_fault |= ov && bus.out_fault_o;
      chk("out_valid", ov, q.size() != 0);
      if (q.size() != 0) begin
         chk("out_pc", bus.out_pc_o, q[0].pc);
         chk("out_inst", bus.out_inst_o, q[0].inst);
         chk("out_fault", bus.out_fault_o, q[0].fault);
`ifdef IFU_INST_CHECK_EN
         chk("out_illegal", bus.out_illegal_o, !q[0].fault && !legal(q[0].inst));
`else
         chk("out_illegal", bus.out_illegal_o, 0);
`endif
      end
      chk("rready", rr, pend);
      if (prev_av) begin
         chk("ar_held", av, 1);
         chk("araddr_held", aa, prev_aa);
      end else if (av) begin
         chk("araddr", aa, fetch_pc);
         chk("slot_free", q.size() < DEPTH, 1);
      end
      if (halted) chk("halt_no_ar", av, 0);
      rd = force_redir || ($urandom_range(0, 99) < p_redir);
      tgt = force_redir ? redir_target : ($urandom & 32'hFFFF_FFFC);
      bus.redirect_valid_i = rd;
      bus.redirect_pc_i = tgt;
      bus.out_ready_i = $urandom_range(0, 99) < p_rdy;
      bus.arready_i = $urandom_range(0, 99) < p_ar;
      rf = 1'b0;
      rdat = $urandom;
      if (pend && rwait == 0) begin
         rf = (fault_en && pend_addr == fault_addr) || ($urandom_range(0, 99) < p_fault);
         rdat = mem_word(pend_addr);
      end
      bus.rvalid_i = pend && rwait == 0;
      bus.rresp_i = rf ? 2'b10 : 2'b00;
      bus.rdata_i = rdat;
      if (pend && rwait != 0) rwait--;
      ar_hs = av && bus.arready_i;
      r_hs = bus.rvalid_i && rr;
      o_hs = ov && bus.out_ready_i;
      @(posedge clk);
      if (o_hs) void'(q.pop_front());
      if (r_hs) begin
         if (!stale && !rd) begin
            if (rf) begin q.push_back('{fetch_pc, 32'h0, 1'b1}); halted = 1'b1; end
            else begin q.push_back('{fetch_pc, rdat, 1'b0}); fetch_pc += 32'd4; end
         end
         pend = 1'b0;
         stale = 1'b0;
      end
      if (rd && (av || pend)) stale = 1'b1;
      if (ar_hs) begin
         pend = 1'b1;
         pend_addr = aa;
         rwait = rdelay < 0 ? int'($urandom_range(0, 3)) : rdelay;
         ar_count++;
         ar_log.push_back(aa);
      end
      prev_av = av && !ar_hs;
      prev_aa = aa;
      if (rd) begin q.delete(); fetch_pc = tgt; halted = 1'b0; end
   endtask
   task automatic run(int n);
      repeat (n) step();
   endtask
   task automatic do_reset();
      rst_n = 1'b0;
      bus.redirect_valid_i = 0; bus.redirect_pc_i = '0; bus.out_ready_i = 0;
      bus.arready_i = 0; bus.rdata_i = '0; bus.rresp_i = '0; bus.rvalid_i = 0;
      q.delete(); ar_log.delete();
      fetch_pc = 32'h8000_0000; pend = 0; stale = 0; halted = 0; prev_av = 0;
      ar_count = 0; rwait = 0; saw_fault = 0; force_redir = 0; fault_en = 0;
      p_ar = 100; p_rdy = 100; p_redir = 0; p_fault = 0; rdelay = 0;
      repeat (2) @(negedge clk);
      chk("rst_arvalid", bus.arvalid_o, 0);
      chk("rst_rready", bus.rready_o, 0);
      chk("rst_out_valid", bus.out_valid_o, 0);
      rst_n = 1'b1;
   endtask
   initial begin
      const_en = 0; const_data = 32'h0;
      // sequential fetch with an always-ready memory
      do_reset();
      const_en = 1; const_data = 32'h0000_0013;
      run(30);
      chk("seq_progress", ar_count >= 8, 1);
      chk("seq_second_ar", ar_log[1], 32'h8000_0004);
      // fill the FIFO, then free one slot
      do_reset();
      p_rdy = 0;
      run(40);
      chk("full_ar_count", ar_count, 4);
      chk("full_no_ar", s_av, 0);
      p_rdy = 100; step(); p_rdy = 0;
      run(20);
      chk("refill_ar_count", ar_count, 5);
      chk("refill_addr", ar_log[ar_log.size()-1], 32'h8000_0010);
      // redirect during DATA with two entries queued
      do_reset();
      p_rdy = 0;
      for (int k = 0; k < 50 && q.size() != 2; k++) step();
      chk("two_queued", q.size(), 2);
      rdelay = 4;
      for (int k = 0; k < 20 && !pend; k++) step();
      chk("in_data", pend, 1);
      force_redir = 1; redir_target = 32'h8000_1000; step(); force_redir = 0;
      step();
      chk("flush_empty", s_ov, 0);
      rdelay = 0;
      begin
         int n;
         n = ar_count;
         for (int k = 0; k < 30 && ar_count == n; k++) step();
         chk("redir_ar_seen", ar_count > n, 1);
      end
      chk("redir_addr", ar_log[ar_log.size()-1], 32'h8000_1000);
      run(10);
      // fault response halts fetching until redirect
      do_reset();
      const_en = 0; fault_en = 1; fault_addr = 32'h8000_0008;
      run(30);
      chk("fault_ar_count", ar_count, 3);
      chk("fault_no_ar", s_av, 0);
      chk("fault_seen", saw_fault, 1);
      fault_en = 0;
      force_redir = 1; redir_target = 32'h8000_0100; step(); force_redir = 0;
      run(20);
      chk("resume_ar", ar_count > 3, 1);
      // arready held low across a redirect
      do_reset();
      p_ar = 0;
      step();
      force_redir = 1; redir_target = 32'h8000_2000; step(); force_redir = 0;
      run(3);
      p_ar = 100;
      run(20);
      chk("hold_ar_count", ar_log.size() >= 2, 1);
      if (ar_log.size() >= 2) begin
         chk("hold_first_addr", ar_log[0], 32'h8000_0000);
         chk("hold_second_addr", ar_log[1], 32'h8000_2000);
      end
      // opcode check on fixed words
      do_reset();
      const_en = 1; const_data = 32'hFFFF_FFFF; p_rdy = 0;
      run(10);
      chk("ill_ff_valid", s_ov, 1);
      chk("ill_ff", s_oi, ILL_FF);
      do_reset();
      const_en = 1; const_data = 32'h0010_0073; p_rdy = 0;
      run(10);
      chk("ebreak_valid", s_ov, 1);
      chk("ebreak_legal", s_oi, 0);
      // random traffic
      do_reset();
      const_en = 0;
      p_ar = 70; p_rdy = 60; p_redir = 3; p_fault = 2; rdelay = -1;
      run(4000);
      chk("rand_progress", ar_count > 100, 1);
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule
